// File: rtl/ram_sdp_be.sv
// Single-clock simple-dual-port RAM with per-lane byte enables, 1- or 2-cycle
// registered read, selectable read-during-write behaviour and a post-reset clear engine.
module ram_sdp_be #(
  parameter int DEPTH          = 32,
  parameter int WIDTH          = 8,
  parameter int LANE           = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AWIDTH        = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int NLANE         = WIDTH / LANE
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              wenable,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [NLANE-1:0]  wbe,
  input  logic              renable,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_INIT,
    ST_RUN
  } state_e;

  localparam state_e            ST_RESET  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_INIT;
  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              clr_en, wr_en, rd_en, waddr_ok, raddr_ok;
  logic [WIDTH-1:0]  rd_word;
  logic [WIDTH-1:0]  d1_q, d2_q;
  logic              v1_q, v2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_INIT: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);
  assign wr_en    = ready_q & wenable & waddr_ok;
  assign rd_en    = ready_q & renable;

  // Forwarding merges only the enabled lanes of the concurrent write into the old word.
  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      rd_word = mem[raddr];
      if (RDW_MODE != 0 && wr_en && waddr == raddr) begin
        for (int unsigned i = 0; i < NLANE; i++) begin
          if (wbe[i]) rd_word[i*LANE +: LANE] = wdata[i*LANE +: LANE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NLANE; i++) begin
        if (wbe[i]) mem[waddr][i*LANE +: LANE] <= wdata[i*LANE +: LANE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      v1_q    <= rd_en;
      v2_q    <= v1_q;
      if (rd_en) d1_q <= rd_word;
      if (v1_q)  d2_q <= d1_q;
    end
  end

  assign ready  = ready_q;
  assign rvalid = (RD_LATENCY == 2) ? v2_q : v1_q;
  assign rdata  = (RD_LATENCY == 2) ? d2_q : d1_q;

endmodule
